// File: rtl/facelet_classifier_stream_if.sv
// Bundle of the capture inputs and the classified-code stream of facelet_classifier_stream.
// slave: the classifier itself. master: the block that feeds faces and takes the code stream.
interface facelet_classifier_stream_if #(
  parameter int unsigned CH_W   = 10,
  parameter int unsigned CODE_W = 3
) ();

  // Capture side
  logic                restart;
  logic                facedone;
  logic [3*CH_W-1:0]   Color1;
  logic [3*CH_W-1:0]   Color2;
  logic [3*CH_W-1:0]   Color3;
  logic [3*CH_W-1:0]   Color4;
  logic [3*CH_W-1:0]   Color5;
  logic [3*CH_W-1:0]   Color6;
  logic [3*CH_W-1:0]   Color7;
  logic [3*CH_W-1:0]   Color8;
  logic [3*CH_W-1:0]   Color9;

  // Status
  logic [2:0]          face_cnt;
  logic                busy;
  logic                done;
  logic                overrun;
  logic                classify_err;

  // Code stream
  logic                out_valid;
  logic                out_ready;
  logic [CODE_W-1:0]   out_code;
  logic [5:0]          out_index;
  logic                out_last;

  modport slave (
    input  restart, facedone,
    input  Color1, Color2, Color3, Color4, Color5, Color6, Color7, Color8, Color9,
    input  out_ready,
    output face_cnt, busy, done, overrun, classify_err,
    output out_valid, out_code, out_index, out_last
  );

  modport master (
    output restart, facedone,
    output Color1, Color2, Color3, Color4, Color5, Color6, Color7, Color8, Color9,
    output out_ready,
    input  face_cnt, busy, done, overrun, classify_err,
    input  out_valid, out_code, out_index, out_last
  );

endinterface

// File: rtl/facelet_classifier_stream.sv
// facelet_classifier_stream: buffers six faces of nine facelet colours, classifies each facelet
// against the six face centres by nearest Manhattan distance (one distance per cycle, ties go
// to the lower face index) and streams the 54 codes over a valid/ready handshake.
// Optional build macro FACELET_HISTO_EN adds a per-colour histogram check driving classify_err.
module facelet_classifier_stream #(
  parameter int unsigned CH_W   = 10,
  parameter int unsigned CODE_W = 3
) (
  input  logic                         Clk,
  input  logic                         Reset,
  facelet_classifier_stream_if.slave   bus
);

  localparam int unsigned ColW  = 3 * CH_W;
  localparam int unsigned DistW = CH_W + 2;

  typedef enum logic [1:0] {StCollect, StClassify, StStream, StDone} state_e;

  state_e              r_state;
  state_e              w_state_nxt;

  logic [ColW-1:0]     r_buf   [54];
  logic [CODE_W-1:0]   r_codes [54];

  logic [2:0]          r_face_cnt;
  logic [5:0]          r_i;
  logic [2:0]          r_j;
  logic [DistW-1:0]    r_best;
  logic [CODE_W-1:0]   r_best_code;

  logic                r_out_valid;
  logic [CODE_W-1:0]   r_out_code;
  logic [5:0]          r_out_index;
  logic                r_out_last;
  logic                r_done;
  logic                r_overrun;
  logic                w_busy;

  logic                w_capture;
  logic                w_cls_last;
  logic                w_xfer;
  logic [5:0]          w_base;
  logic [5:0]          w_ctr_slot;
  logic [ColW-1:0]     w_pix;
  logic [ColW-1:0]     w_ctr;
  logic [DistW-1:0]    w_dist;
  logic                w_take;
  logic [CODE_W-1:0]   w_code_new;

  function automatic logic [CH_W-1:0] abs_diff(input logic [CH_W-1:0] a,
                                               input logic [CH_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  assign w_capture  = (r_state == StCollect) && bus.facedone && !bus.restart;
  assign w_cls_last = (r_state == StClassify) && (r_i == 6'd53) && (r_j == 3'd5);
  assign w_xfer     = (r_state == StStream) && r_out_valid && bus.out_ready && !bus.restart;
  assign w_base     = 6'(r_face_cnt) * 6'd9;
  assign w_ctr_slot = 6'(r_j) * 6'd9 + 6'd4;

  // Distance of facelet i to the centre of face j, and the running-best update decision
  always_comb begin
    w_pix  = r_buf[r_i];
    w_ctr  = r_buf[w_ctr_slot];
    w_dist = DistW'(abs_diff(w_pix[3*CH_W-1:2*CH_W], w_ctr[3*CH_W-1:2*CH_W]))
           + DistW'(abs_diff(w_pix[2*CH_W-1:CH_W],   w_ctr[2*CH_W-1:CH_W]))
           + DistW'(abs_diff(w_pix[CH_W-1:0],        w_ctr[CH_W-1:0]));
    // Strict compare keeps the lower face index on ties
    w_take     = (r_j == 3'd0) || (w_dist < r_best);
    w_code_new = w_take ? CODE_W'(r_j) : r_best_code;
  end

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= StCollect;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; restart overrides everything
  always_comb begin
    w_state_nxt = r_state;
    if (bus.restart) begin
      w_state_nxt = StCollect;
    end else begin
      unique case (r_state)
        StCollect:  if (w_capture && (r_face_cnt == 3'd5)) w_state_nxt = StClassify;
        StClassify: if (w_cls_last) w_state_nxt = StStream;
        StStream:   if (w_xfer && (r_out_index == 6'd53)) w_state_nxt = StDone;
        StDone:     w_state_nxt = StDone;
        default:    w_state_nxt = StCollect;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    w_busy = (r_state == StClassify) || (r_state == StStream);
  end

  // Facelet buffer write; contents survive reset and restart
  always_ff @(posedge Clk) begin
    if (Reset && w_capture) begin
      r_buf[w_base + 6'd0] <= bus.Color1;
      r_buf[w_base + 6'd1] <= bus.Color2;
      r_buf[w_base + 6'd2] <= bus.Color3;
      r_buf[w_base + 6'd3] <= bus.Color4;
      r_buf[w_base + 6'd4] <= bus.Color5;
      r_buf[w_base + 6'd5] <= bus.Color6;
      r_buf[w_base + 6'd6] <= bus.Color7;
      r_buf[w_base + 6'd7] <= bus.Color8;
      r_buf[w_base + 6'd8] <= bus.Color9;
    end
  end

  // Code memory write at the last centre of each facelet
  always_ff @(posedge Clk) begin
    if (Reset && !bus.restart && (r_state == StClassify) && (r_j == 3'd5)) begin
      r_codes[r_i] <= w_code_new;
    end
  end

  // Face counter and classification counters
  always_ff @(posedge Clk) begin
    if (!Reset || bus.restart) begin
      r_face_cnt  <= 3'd0;
      r_i         <= 6'd0;
      r_j         <= 3'd0;
      r_best      <= '0;
      r_best_code <= '0;
    end else begin
      if (w_capture) begin
        r_face_cnt <= r_face_cnt + 3'd1;
      end
      if (r_state == StCollect) begin
        r_i <= 6'd0;
        r_j <= 3'd0;
      end else if (r_state == StClassify) begin
        r_best      <= w_take ? w_dist : r_best;
        r_best_code <= w_code_new;
        if (r_j == 3'd5) begin
          r_j <= 3'd0;
          r_i <= r_i + 6'd1;
        end else begin
          r_j <= r_j + 3'd1;
        end
      end
    end
  end

  // Output beat registers: first beat loaded as CLASSIFY ends, next one after each transfer
  always_ff @(posedge Clk) begin
    if (!Reset || bus.restart) begin
      r_out_valid <= 1'b0;
      r_out_code  <= '0;
      r_out_index <= 6'd0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else if (w_cls_last) begin
      r_out_valid <= 1'b1;
      r_out_code  <= r_codes[0];
      r_out_index <= 6'd0;
      r_out_last  <= 1'b0;
    end else if (w_xfer) begin
      if (r_out_index == 6'd53) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        r_done      <= 1'b1;
      end else begin
        r_out_code  <= r_codes[r_out_index + 6'd1];
        r_out_index <= r_out_index + 6'd1;
        r_out_last  <= (r_out_index == 6'd52);
      end
    end
  end

  // Sticky overrun: a face arriving when the buffer is not accepting
  always_ff @(posedge Clk) begin
    if (!Reset || bus.restart) begin
      r_overrun <= 1'b0;
    end else if (bus.facedone && (r_state != StCollect)) begin
      r_overrun <= 1'b1;
    end
  end

`ifdef FACELET_HISTO_EN
  logic [3:0] r_histo [6];
  logic       r_classify_err;
  logic       w_histo_bad;

  // A well-formed cube has exactly nine facelets of every colour, counting the final write
  always_comb begin
    logic [3:0] w_cnt;
    w_cnt       = '0;
    w_histo_bad = 1'b0;
    for (int b = 0; b < 6; b++) begin
      w_cnt = r_histo[b] + ((w_code_new == CODE_W'(b)) ? 4'd1 : 4'd0);
      if (w_cnt != 4'd9) w_histo_bad = 1'b1;
    end
  end

  // Histogram accumulation during CLASSIFY and sticky error flag
  always_ff @(posedge Clk) begin
    if (!Reset || bus.restart) begin
      for (int b = 0; b < 6; b++) r_histo[b] <= 4'd0;
      r_classify_err <= 1'b0;
    end else begin
      if (r_state == StCollect) begin
        for (int b = 0; b < 6; b++) r_histo[b] <= 4'd0;
      end else if ((r_state == StClassify) && (r_j == 3'd5)) begin
        r_histo[w_code_new] <= r_histo[w_code_new] + 4'd1;
      end
      if (w_cls_last && w_histo_bad) begin
        r_classify_err <= 1'b1;
      end
    end
  end

  assign bus.classify_err = r_classify_err;
`else
  assign bus.classify_err = 1'b0;
`endif

  assign bus.face_cnt  = r_face_cnt;
  assign bus.busy      = w_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.out_code  = r_out_code;
  assign bus.out_index = r_out_index;
  assign bus.out_last  = r_out_last;
  assign bus.done      = r_done;
  assign bus.overrun   = r_overrun;

endmodule
